// File: rtl/allophone_queue_pkg.sv
// Shared definitions for the allophone queue: code width, handshake states and pause codes.
package allophone_queue_pkg;

  localparam int unsigned ALLO_W = 6;

  typedef enum logic [1:0] {
    StIdle,
    StStrobe,
    StWaitAck
  } hs_state_e;

  localparam logic [ALLO_W-1:0] PA1 = 6'h00;
  localparam logic [ALLO_W-1:0] PA2 = 6'h01;
  localparam logic [ALLO_W-1:0] PA3 = 6'h02;
  localparam logic [ALLO_W-1:0] PA4 = 6'h03;
  localparam logic [ALLO_W-1:0] PA5 = 6'h04;

endpackage

// File: rtl/allophone_queue_fifo.sv
// Synchronous allophone FIFO; full/empty derive from the occupancy counter, pointers wrap.
module allophone_queue_fifo
  import allophone_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned LVL_W = 5
) (
  input  logic              clk,
  input  logic              rst_an,
  input  logic              push,
  input  logic [ALLO_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic [ALLO_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [LVL_W-1:0]  level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [ALLO_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              push_en, pop_en;

  assign full     = (level_q == LVL_W'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign pop_data = mem_q[rd_ptr_q];

  // Flush wins over a same-cycle push; a pop alongside a flush is harmless.
  assign push_en = push & ~full & ~flush;
  assign pop_en  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      level_d = level_q + LVL_W'(push_en) - LVL_W'(pop_en);
    end
  end

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/allophone_queue.sv
// Host-side allophone buffer: FIFO plus ldq/data_stb load handshake toward the speech core.
module allophone_queue
  import allophone_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_an,
  input  logic [ALLO_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic              flush,
  input  logic              ldq,
  output logic [ALLO_W-1:0] data_in,
  output logic              data_stb,
  output logic [LVL_W-1:0]  level,
  output logic              speaking
);

  hs_state_e         state_q, state_d;
  logic              pop;
  logic              full, empty;
  logic [ALLO_W-1:0] head;
  logic [ALLO_W-1:0] data_q;
  logic              stb_q;

  allophone_queue_fifo #(
    .DEPTH(DEPTH),
    .LVL_W(LVL_W)
  ) u_fifo (
    .clk      (clk),
    .rst_an   (rst_an),
    .push     (wr_valid),
    .push_data(wr_data),
    .pop      (pop),
    .flush    (flush),
    .pop_data (head),
    .full     (full),
    .empty    (empty),
    .level    (level)
  );

  // WAIT_ACK holds off the next pop until ldq is seen low: one code per ldq pulse.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ldq && !empty) begin
          pop     = 1'b1;
          state_d = StStrobe;
        end
      end
      StStrobe:  state_d = StWaitAck;
      StWaitAck: if (!ldq) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      state_q <= StIdle;
      stb_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      stb_q   <= pop;
      if (pop) data_q <= head;
    end
  end

  assign data_stb = stb_q;
  assign data_in  = data_q;
  assign wr_ready = ~full;
  assign speaking = (level != '0) | (state_q != StIdle);

endmodule
